e_mdu: RTL and testbench

- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline; it is the consumer of the D->E pipeline register's operand outputs (E_RS, E_RT) and the E-stage MDU opcode.
- Owns the HI/LO registers and models multi-cycle latency with a busy counter.
- Drives busy back to the hazard unit, which deasserts the D->E register write-enable and stalls D while any MDU instruction waits.
- Results become architecturally visible in HI/LO only when the operation retires.

---
 rtl/e_mdu.sv | 155 +++++++++++++++
 tb/tb_e_mdu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, models multi-cycle latency
// with a countdown, and commits the full result to HI/LO only on retirement.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Full 64-bit product as {hi, lo}.
  function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
    sb = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
    return sa * sb;
  endfunction

  // Divide on magnitudes so INT_MIN / -1 wraps instead of trapping; returns {rem, quo}.
  function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    ma = neg_a ? -a : a;
    mb = neg_b ? -b : b;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (neg_a ^ neg_b) q = -q;
    if (neg_a) r = -r;
    return {r, q};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_p1, pend_hi_d;
  logic [31:0]      pend_lo_p1, pend_lo_d;
  logic             wr_vld_p1, wr_vld_d;
  logic [31:0]      hi_d, lo_d;
  logic [63:0]      res;
  logic             is_div;

  assign busy    = (state_q == S_RUN);
  assign start   = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU) && !busy;
  assign is_div  = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
  assign mdu_out = (mdu_op == OP_MFHI) ? hi :
                   (mdu_op == OP_MFLO) ? lo : 32'd0;

  always_comb begin
    res = 64'd0;
    case (mdu_op)
      OP_MULT:  res = mul_full(rs, rt, 1'b1);
      OP_MULTU: res = mul_full(rs, rt, 1'b0);
      OP_DIV:   res = div_full(rs, rt, 1'b1);
      OP_DIVU:  res = div_full(rs, rt, 1'b0);
      default:  res = 64'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_p1;
    pend_lo_d = pend_lo_p1;
    wr_vld_d  = wr_vld_p1;
    hi_d      = hi;
    lo_d      = lo;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pend_hi_d = res[63:32];
          pend_lo_d = res[31:0];
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          wr_vld_d  = !(is_div && (rt == 32'd0));
          cnt_d     = is_div ? DIV_N : MULT_N;
          state_d   = S_RUN;
        end else if (mdu_op == OP_MTHI) begin
          hi_d = rs;
        end else if (mdu_op == OP_MTLO) begin
          lo_d = rs;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          if (wr_vld_p1) begin
            hi_d = pend_hi_p1;
            lo_d = pend_lo_p1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Retirement / register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_hi_p1 <= 32'd0;
      pend_lo_p1 <= 32'd0;
      wr_vld_p1  <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_hi_p1 <= pend_hi_d;
      pend_lo_p1 <= pend_lo_d;
      wr_vld_p1  <= wr_vld_d;
      hi         <= hi_d;
      lo         <= lo_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed scenarios with literal results plus random traffic
// checked every cycle against a retire-time model of HI/LO and busy.
module tb_e_mdu;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mdu_op;
  logic [31:0] rs, rt;
  logic        start, busy;
  logic [31:0] hi, lo, mdu_out;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst(rst), .mdu_op(mdu_op), .rs(rs), .rt(rt),
    .start(start), .busy(busy), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  // Model: an accepted op retires at edge index start_edge + N.
  typedef struct {
    logic [31:0] hi, lo, phi, plo;
    logic        pwr;
    longint      retire, cyc;
  } mstate_t;

  mstate_t m = '{hi: 32'd0, lo: 32'd0, phi: 32'd0, plo: 32'd0, pwr: 1'b0, retire: 0, cyc: 0};

  function automatic mstate_t model_step(mstate_t s, logic r, logic [3:0] op,
                                         logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, rem;
    longint unsigned ua, ub, p;
    s.cyc = s.cyc + 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (r) begin
      s.hi = 0; s.lo = 0; s.phi = 0; s.plo = 0; s.pwr = 0; s.retire = 0;
    end else if (s.cyc <= s.retire) begin
      if (s.cyc == s.retire && s.pwr) begin
        s.hi = s.phi;
        s.lo = s.plo;
      end
    end else begin
      case (op)
        4'd1: begin p = longint'(sa * sb); {s.phi, s.plo} = p; s.pwr = 1; s.retire = s.cyc + MULT_N; end
        4'd2: begin p = ua * ub; {s.phi, s.plo} = p; s.pwr = 1; s.retire = s.cyc + MULT_N; end
        4'd3: begin
          s.pwr = (b != 0);
          if (b != 0) begin q = sa / sb; rem = sa % sb; s.plo = q[31:0]; s.phi = rem[31:0]; end
          s.retire = s.cyc + DIV_N;
        end
        4'd4: begin
          s.pwr = (b != 0);
          if (b != 0) begin s.plo = 32'(ua / ub); s.phi = 32'(ua % ub); end
          s.retire = s.cyc + DIV_N;
        end
        4'd5: s.hi = a;
        4'd6: s.lo = a;
        default: ;
      endcase
    end
    return s;
  endfunction

  always @(posedge clk) m <= model_step(m, rst, mdu_op, rs, rt);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic eb;
      eb = (m.cyc < m.retire);
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("hi", hi, m.hi);
      chk("lo", lo, m.lo);
      chk("start", {31'd0, start}, {31'd0, (mdu_op >= 4'd1 && mdu_op <= 4'd4 && !eb)});
      chk("mdu_out", mdu_out, (mdu_op == 4'd7) ? m.hi : (mdu_op == 4'd8) ? m.lo : 32'd0);
    end
  end

  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r = 1'b0);
    rst = r; mdu_op = op; rs = a; rt = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(4'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; mdu_op = 4'd0; rs = 32'd0; rt = 32'd0;
    apply(4'd0, 32'd0, 32'd0, 1'b1);
    chk_en = 1'b1;
    apply(4'd0, 32'd0, 32'd0, 1'b1);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    apply(4'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy_first", {31'd0, busy}, 32'd1);
    idle(4);
    chk("mult_busy_last", {31'd0, busy}, 32'd1);
    chk("mult_hi_held", hi, 32'd0);
    idle(1);
    chk("mult_busy_done", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    apply(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    apply(4'd3, 32'hFFFF_FFF9, 32'd2);
    idle(9);
    chk("div_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    apply(4'd5, 32'h11, 32'd0);
    apply(4'd6, 32'h22, 32'd0);
    apply(4'd4, 32'd7, 32'd0);
    idle(9);
    chk("dz_busy", {31'd0, busy}, 32'd1);
    idle(1);
    chk("dz_busy_done", {31'd0, busy}, 32'd0);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    apply(4'd5, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    apply(4'd7, 32'd0, 32'd0);
    chk("mfhi_out", mdu_out, 32'hDEAD_BEEF);

    apply(4'd1, 32'd3, 32'd4);
    apply(4'd0, 32'd0, 32'd0);
    apply(4'd6, 32'h55, 32'd0);
    idle(3);
    chk("ign_lo", lo, 32'd12);
    chk("ign_hi", hi, 32'd0);

    apply(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    apply(4'd3, 32'd100, 32'd7);
    idle(3);
    apply(4'd0, 32'd0, 32'd0, 1'b1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    idle(10);
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      apply(op, rnd32(), rnd32(), ($urandom_range(0, 79) == 0));
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
